muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Iterative 32-bit multiply/divide unit that sits beside the execute-stage ALU. It accepts one operation from the execute stage and runs a shift-add multiply or a restoring divide over WIDTH cycles. While the operation runs, it drives a stall that the pipeline controller ANDs into the execute stage-register enable (EN_REG). Results land in dedicated hi/lo registers that the execute-stage forwarding muxes can read.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  request a new operation; sampled only when accepting (state IDLE or DONE)
op  in  2  00 MUL signed, 01 MULU, 10 DIV signed, 11 DIVU
opA  in  WIDTH  forwarded rs operand (multiplicand / dividend)
opB  in  WIDTH  forwarded rt operand (multiplier / divisor)
abort  in  1  pipeline flush; kills an in-flight operation
stall  out  1  freeze the execute stage register
busy  out  1  state == RUN
done  out  1  one-cycle pulse; hi/lo are valid this cycle
div_by_zero  out  1  set with done when a DIV/DIVU had opB == 0; held until next accept
hi  out  WIDTH  MUL: upper product; DIV: remainder
lo  out  WIDTH  MUL: lower product; DIV: quotient

Behaviour:
- Reset (reset == 0, async): state=IDLE, counter=0; stall, busy, done and div_by_zero = 0; hi = lo = 0. Any in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- Accept = start & (state == IDLE | state == DONE).
- stall = accept | (state == RUN). The stall is combinational, so the pipeline freezes in the same cycle as start.
- On accept with divide op and opB == 0: go to DONE next cycle. Set hi = opA, lo = all-ones, div_by_zero = 1. No RUN cycles.
- Otherwise on accept:
  - Latch |opA| and |opB| (magnitudes for signed ops; raw values for unsigned).
  - Latch result sign: MUL = signA ^ signB. DIV quotient = signA ^ signB; DIV remainder = signA.
  - Clear div_by_zero and the counter; go to RUN.
- RUN: one iteration per cycle, counter 0..WIDTH-1.
  - MUL: add-shift over a 2*WIDTH accumulator.
  - DIV: restoring shift-subtract over a remainder/quotient pair.
- On the cycle the counter reaches WIDTH-1: write hi/lo (two's-complement negation applied per the latched signs); go to DONE.
- DONE: done = 1 for exactly one cycle; stall = 0 unless start is high again.
  - DONE → RUN if an accept occurs this cycle, else → IDLE.
  - hi/lo hold until the next result write; they are not cleared by accept.
- Latency: start in cycle 0, RUN cycles 1..WIDTH, done in cycle WIDTH+1. stall is high for WIDTH+1 cycles (0..WIDTH).
- Arithmetic:
  - MUL/MULU: full 2*WIDTH product.
  - Signed DIV truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF wraps: lo = 0x80000000, hi = 0, no flag.
- abort:
  - In RUN: next state IDLE; no done; hi/lo and div_by_zero unchanged.
  - In IDLE/DONE: abort takes priority over start (no accept); DONE still pulses done.
  - Same cycle as the final iteration: abort wins, no result write.
- start while RUN is ignored; the caller holds start through the stall.

Test Plan:
- MULU opA=0xFFFFFFFF, opB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done in cycle 33; stall high cycles 0..32; busy high cycles 1..32.
- MUL opA=0xFFFFFFFD (-3), opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then back-to-back MUL opA=opB=0x80000000 issued in the DONE cycle -> hi=0x40000000, lo=0, done exactly 33 cycles after the second start.
- DIVU 100/7 -> lo=14, hi=2. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU 5/0 -> done in cycle 1, div_by_zero=1, hi=5, lo=0xFFFFFFFF; stall high only in cycle 0.
- Complete MULU 3*4 (lo=12). Then start DIV 9/2 and pulse abort in cycle 10 -> busy/stall low from cycle 11, no done, lo stays 12. Repeat with abort in the final RUN cycle -> no done, lo stays 12.
- Drive reset low mid-RUN at cycle 15 -> state, outputs and hi/lo all 0 immediately. Release, then DIVU 9/3 -> lo=3, hi=0 after 33 cycles.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit beside the execute-stage ALU.
// Runs a shift-add multiply or a restoring divide, one bit per cycle over WIDTH
// cycles, and stalls the execute stage while it runs.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   start, op         request and opcode (00 MUL, 01 MULU, 10 DIV, 11 DIVU)
//   opA, opB          multiplicand/dividend, multiplier/divisor
//   abort             pipeline flush, kills an in-flight operation
//   stall             combinational freeze for the execute stage register
//   busy              operation iterating
//   done              one-cycle result-valid pulse
//   div_by_zero       last divide had a zero divisor, held until next accept
//   hi, lo            MUL: upper/lower product; DIV: remainder/quotient
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             abort,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               sign_p_q, sign_p_d;  // product / quotient sign
  logic               sign_r_q, sign_r_d;  // remainder sign
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;  // MUL: upper accumulator; DIV: partial remainder
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;  // MUL: multiplier/low product; DIV: dividend/quotient
  logic [WIDTH-1:0]   opnd_q, opnd_d;      // MUL: |multiplicand|; DIV: |divisor|
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic               is_signed;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   div_hi_n, div_lo_n;
  logic [WIDTH-1:0]   it_hi, it_lo;
  logic [DW-1:0]      prod, prod_neg;

  // Operand conditioning at accept
  always_comb begin
    accept    = start & ~abort & ((state_q == IDLE) | (state_q == DONE));
    is_signed = ~op[0];
    sign_a    = is_signed & opA[WIDTH-1];
    sign_b    = is_signed & opB[WIDTH-1];
    a_mag     = sign_a ? ({WIDTH{1'b0}} - opA) : opA;
    b_mag     = sign_b ? ({WIDTH{1'b0}} - opB) : opB;
  end

  // One iteration of each algorithm; the latched op selects which is kept
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    // Partial remainder is always below the divisor, so the difference fits WIDTH bits
    div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opnd_q});
    div_diff = div_sh[WIDTH-1:0] - opnd_q;
    div_hi_n = div_ge ? div_diff : div_sh[WIDTH-1:0];
    div_lo_n = {acc_lo_q[WIDTH-2:0], div_ge};

    it_hi    = is_div_q ? div_hi_n : mul_hi_n;
    it_lo    = is_div_q ? div_lo_n : mul_lo_n;
    prod     = {it_hi, it_lo};
    prod_neg = {DW{1'b0}} - prod;
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_p_d = sign_p_q;
    sign_r_d = sign_r_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_hi_d = it_hi;
          acc_lo_d = it_lo;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
            if (is_div_q) begin
              lo_d = sign_p_q ? ({WIDTH{1'b0}} - it_lo) : it_lo;
              hi_d = sign_r_q ? ({WIDTH{1'b0}} - it_hi) : it_hi;
            end else begin
              {hi_d, lo_d} = sign_p_q ? prod_neg : prod;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          if (op[1] && (opB == {WIDTH{1'b0}})) begin
            // Divide by zero resolves immediately without iterating
            state_d = DONE;
            hi_d    = opA;
            lo_d    = {WIDTH{1'b1}};
            dbz_d   = 1'b1;
          end else begin
            state_d  = RUN;
            cnt_d    = '0;
            dbz_d    = 1'b0;
            is_div_d = op[1];
            sign_p_d = sign_a ^ sign_b;
            sign_r_d = sign_a;
            acc_hi_d = '0;
            acc_lo_d = op[1] ? a_mag : b_mag;
            opnd_d   = op[1] ? b_mag : a_mag;
          end
        end
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_p_q <= 1'b0;
      sign_r_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_p_q <= sign_p_d;
      sign_r_q <= sign_r_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  // Stall must rise in the start cycle itself, so it includes the live accept
  assign stall       = accept | (state_q == RUN);
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases with literal
// expectations, then randomized traffic against a cycle-level behavioural model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  opA = '0;
  logic [W-1:0]  opB = '0;
  logic          stall, busy, done, dbz;
  logic [W-1:0]  hi, lo;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .start       (start),
    .op          (op),
    .opA         (opA),
    .opB         (opB),
    .abort       (abort),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .div_by_zero (dbz),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic; divisor assumed nonzero
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic signed [31:0] q, r;
    logic [63:0] res;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    res = '0;
    case (o)
      2'b00: begin sp = sa * sb; res = sp; end
      2'b01: res = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res = {32'h0, 32'h8000_0000};
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          res = {r, q};
        end
      end
      default: res = {a % b, a / b};
    endcase
    return res;
  endfunction

  // Behavioural model: cycles left in the iteration, pending result, visible regs
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic         m_dbz = 1'b0;
  logic [31:0]  m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         m_acc;

  assign m_acc = (m_left == 0) && start && !abort;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left > 0) begin
      m_done <= 1'b0;
      if (abort) begin
        m_left <= 0;
      end else if (m_left == 1) begin
        m_hi   <= p_hi;
        m_lo   <= p_lo;
        m_done <= 1'b1;
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
      end
    end else begin
      m_done <= 1'b0;
      if (m_acc) begin
        if (op[1] && opB == 32'h0) begin
          m_hi   <= opA;
          m_lo   <= 32'hFFFF_FFFF;
          m_dbz  <= 1'b1;
          m_done <= 1'b1;
        end else begin
          {p_hi, p_lo} <= ref_res(op, opA, opB);
          m_dbz  <= 1'b0;
          m_left <= W;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("stall", 64'(stall), 64'(m_acc || (m_left > 0)));
    chk("busy",  64'(busy),  64'(m_left > 0));
    chk("done",  64'(done),  64'(m_done));
    chk("div_by_zero", 64'(dbz), 64'(m_dbz));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
  end

  // Issue in the current cycle (cycle 0) and return the cycle index of done
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    start = 1'b1; op = o; opA = a; opB = b;
    n = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end while (!done && n < 100);
  endtask

  // Issue, pulse abort in cycle ac, and count any done pulses over 40 cycles
  task automatic abort_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int ac, output int d);
    start = 1'b1; op = o; opA = a; opB = b;
    d = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = (c == ac);
      if (done) d++;
    end
    abort = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int n, d;
    #2;
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_busy",  64'(busy),  64'd0);
    chk("reset_done",  64'(done),  64'd0);
    chk("reset_hi",    64'(hi),    64'd0);
    chk("reset_lo",    64'(lo),    64'd0);
    #10 rst_n = 1'b1;
    step();

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    chk("mulu_lat", 64'(n), 64'd33);
    chk("mulu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("mulu_lo", 64'(lo), 64'h0000_0001);
    step();

    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, n);
    chk("mul_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mul_neg_lo", 64'(lo), 64'hFFFF_FFEB);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, n);
    chk("mul_b2b_lat", 64'(n), 64'd33);
    chk("mul_b2b_hi", 64'(hi), 64'h4000_0000);
    chk("mul_b2b_lo", 64'(lo), 64'h0);
    step();

    do_op(2'b11, 32'd100, 32'd7, n);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);
    step();
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    step();
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'h0);
    chk("div_ovf_dbz", 64'(dbz), 64'd0);
    step();

    do_op(2'b11, 32'd5, 32'd0, n);
    chk("dbz_lat", 64'(n), 64'd1);
    chk("dbz_flag", 64'(dbz), 64'd1);
    chk("dbz_hi", 64'(hi), 64'd5);
    chk("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
    step();

    do_op(2'b01, 32'd3, 32'd4, n);
    chk("mulu34_lo", 64'(lo), 64'd12);
    step();
    abort_op(2'b10, 32'd9, 32'd2, 10, d);
    chk("abort10_done", 64'(d), 64'd0);
    chk("abort10_lo", 64'(lo), 64'd12);
    chk("abort10_busy", 64'(busy), 64'd0);
    abort_op(2'b10, 32'd9, 32'd2, 32, d);
    chk("abort32_done", 64'(d), 64'd0);
    chk("abort32_lo", 64'(lo), 64'd12);

    start = 1'b1; op = 2'b01; opA = 32'($urandom); opB = 32'($urandom);
    for (int c = 1; c <= 15; c++) begin
      step();
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_dbz",   64'(dbz),   64'd0);
    chk("rst_hi",    64'(hi),    64'd0);
    chk("rst_lo",    64'(lo),    64'd0);
    step();
    rst_n = 1'b1;
    step();
    do_op(2'b11, 32'd9, 32'd3, n);
    chk("post_rst_lat", 64'(n), 64'd33);
    chk("post_rst_lo", 64'(lo), 64'd3);
    chk("post_rst_hi", 64'(hi), 64'd0);
    step();

    for (int c = 0; c < 6000; c++) begin
      start = ($urandom % 4 == 0);
      op    = 2'($urandom);
      opA   = pick();
      opB   = pick();
      abort = ($urandom % 50 == 0);
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
